// File: rtl/arb_pkg.sv
// Shared types and constants for the hold-capable round-robin arbiter.
package arb_pkg;

    typedef enum logic {
        ARB_FIXED = 1'b0,
        ARB_RR    = 1'b1
    } arb_mode_e;

    localparam int HOLD_CNT_W = 8;

endpackage

// File: rtl/rr_pick.sv
// Combinational circular search: first set request at or after a start index.
module rr_pick #(
    parameter int NUM_PORTS = 5,
    parameter int ID_W      = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [ID_W-1:0]      start,
    output logic                 found,
    output logic [ID_W-1:0]      idx
);

    logic [NUM_PORTS-1:0] rot;
    logic [ID_W-1:0]      offs;
    logic [ID_W:0]        sum;

    always_comb begin
        // Doubling the vector turns the wrap-around into a plain shift.
        rot   = NUM_PORTS'({req, req} >> start);
        found = |req;
        offs  = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (rot[i]) begin
                offs = ID_W'(i);
            end
        end
        sum = {1'b0, start} + {1'b0, offs};
        if (sum >= (ID_W+1)'(NUM_PORTS)) begin
            sum = sum - (ID_W+1)'(NUM_PORTS);
        end
        idx = sum[ID_W-1:0];
    end

endmodule

// File: rtl/rr_hold_arbiter.sv
// N-port arbiter, fixed or round-robin at run time, with bounded grant hold.
module rr_hold_arbiter
    import arb_pkg::*;
#(
    parameter int NUM_PORTS = 5,
    parameter int MAX_HOLD  = 4,
    localparam int ID_W     = $clog2(NUM_PORTS)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 mode_i,
    input  logic [NUM_PORTS-1:0] req_i,
    output logic [NUM_PORTS-1:0] gnt_o,
    output logic [ID_W-1:0]      gnt_id_o,
    output logic                 gnt_valid_o
);

    logic [NUM_PORTS-1:0]  gnt_q;
    logic [ID_W-1:0]       id_q;
    logic                  valid_q;
    logic [ID_W-1:0]       ptr_q;
    logic [HOLD_CNT_W-1:0] hold_q;

    arb_mode_e       mode;
    logic            keep;
    logic [ID_W-1:0] start;
    logic            found;
    logic [ID_W-1:0] win;
    logic [ID_W-1:0] ptr_nxt;

    assign mode  = arb_mode_e'(mode_i);
    assign keep  = (|(gnt_q & req_i)) &&
                   (hold_q < HOLD_CNT_W'(MAX_HOLD - 1));
    assign start = (mode == ARB_RR) ? ptr_q : '0;
    assign ptr_nxt = (win == ID_W'(NUM_PORTS - 1)) ? '0 : win + 1'b1;

    rr_pick #(
        .NUM_PORTS(NUM_PORTS),
        .ID_W     (ID_W)
    ) u_pick (
        .req  (req_i),
        .start(start),
        .found(found),
        .idx  (win)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            gnt_q   <= '0;
            id_q    <= '0;
            valid_q <= 1'b0;
            ptr_q   <= '0;
            hold_q  <= '0;
        end else if (keep) begin
            hold_q <= hold_q + 1'b1;
        end else if (found) begin
            gnt_q   <= NUM_PORTS'(1) << win;
            id_q    <= win;
            valid_q <= 1'b1;
            hold_q  <= '0;
            if (mode == ARB_RR) begin
                ptr_q <= ptr_nxt;
            end
        end else begin
            gnt_q   <= '0;
            id_q    <= '0;
            valid_q <= 1'b0;
            hold_q  <= '0;
        end
    end

    assign gnt_o       = gnt_q;
    assign gnt_id_o    = id_q;
    assign gnt_valid_o = valid_q;

endmodule
